sa_cdc_hs_tx: RTL and testbench
===============================

SA_CDC_HS_TX -- requirements
Module: sa_cdc_hs_tx

Interface
REQ-001 Parameter: DW, default 32, width of the transferred data word.
REQ-002 Parameter: TIMEOUT, default 1023, WAIT_ACK cycle limit before err_to sets; 0 disables the timeout.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr_  input  1  reset, asynchronous, active-low.
REQ-005 src_valid  input  1  source offers src_data this cycle.
REQ-006 src_data  input  DW  word to transmit.
REQ-007 src_ready  output  1  block accepts a word this cycle.
REQ-008 tx_req  output  1  request level; toggles once per transfer (two-phase).
REQ-009 tx_data  output  DW  registered data, held stable from the req toggle until the ack is seen.
REQ-010 tx_ack  input  1  acknowledge toggle from the receiving domain; asynchronous to clk.
REQ-011 busy  output  1  transfer outstanding (state WAIT_ACK).
REQ-012 err_to  output  1  sticky: ack timeout occurred.
REQ-013 err_proto  output  1  sticky: ack toggled while no transfer was outstanding.

Function
REQ-014 tx_ack shall pass through exactly 3 flops clocked by clk (ack_s0->ack_s1->ack_sync) before any use; no other logic touches raw tx_ack.
REQ-015 FSM states shall be IDLE and WAIT_ACK only.
REQ-016 src_ready shall be 1 iff state==IDLE, decoded from the registered state only (no combinational path from src_valid or tx_ack).
REQ-017 IDLE with src_valid=1 shall, at the next edge, load tx_data<=src_data, invert tx_req, clear the timeout counter, and enter WAIT_ACK.
REQ-018 IDLE with src_valid=0 shall leave tx_data and tx_req unchanged.
REQ-019 WAIT_ACK shall return to IDLE at the first edge where ack_sync==tx_req; tx_data is not modified in WAIT_ACK.
REQ-020 src_valid in WAIT_ACK shall be ignored; no word is lost because src_ready=0.
REQ-021 Latency: the tx_ack edge is sampled at edge N; ack_sync matches after edge N+2; state is IDLE after edge N+3, so src_ready=1 from edge N+3.
REQ-022 Minimum spacing between accepted words shall be 1 + receiver round trip + 4 cycles; two accepts in consecutive cycles are impossible.
REQ-023 Timeout counter: width ceil(log2(TIMEOUT+1)); increments each WAIT_ACK cycle and saturates at TIMEOUT; err_to<=1 when it reaches TIMEOUT. The transfer is not aborted; the FSM keeps waiting.
REQ-024 err_proto<=1 at any edge where state==IDLE and ack_sync!=tx_req.
REQ-025 err_to and err_proto shall clear only on reset.
REQ-026 busy shall equal (state==WAIT_ACK).

Reset
REQ-027 While clr_=0 (asynchronous): state=IDLE, tx_req=0, tx_data=0, sync flops=0, counter=0, err_to=0, err_proto=0; hence src_ready=1, busy=0.
REQ-028 Reset mid-transfer shall abandon the transfer; the receiver is reset by the same clr_, so req and ack both restart at 0.
REQ-029 First accept after clr_ deasserts shall be allowed in the first cycle out of reset.

Verification
REQ-030 Reset then src_valid=1, src_data=0xDEADBEEF for 1 cycle -> next cycle: tx_data=0xDEADBEEF, tx_req=1, busy=1, src_ready=0.
REQ-031 tx_ack raised 5 cycles after the req toggle -> src_ready returns exactly 3 cycles after the sampling edge; tx_data stable throughout; err flags 0.
REQ-032 Second word 0x12345678 after the first completes -> tx_req toggles back to 0, tx_data=0x12345678; the ack falling edge completes the transfer with the same 3-cycle latency.
REQ-033 TIMEOUT=8 and tx_ack held constant after the req toggle -> err_to=1 after 8 WAIT_ACK cycles, busy stays 1; a late ack then completes normally and err_to stays 1.
REQ-034 tx_ack toggled in IDLE -> err_proto=1 three cycles later; clr_ pulse clears it.
REQ-035 clr_ asserted in WAIT_ACK between clock edges -> all outputs reach their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sa_cdc_hs_tx_if.sv
// Two-phase CDC transmit handshake bundle: source-side word offer plus the
// req/data/ack wires that cross into the receiving clock domain.
interface sa_cdc_hs_tx_if #(
  parameter int DW = 32
);
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          tx_ack;

  // Transmitter side: accepts words from the source, drives req/data, sees ack.
  modport master (
    input  src_valid,
    input  src_data,
    output src_ready,
    output tx_req,
    output tx_data,
    input  tx_ack
  );

  // Environment side: source of words and the receiving domain's ack.
  modport slave (
    output src_valid,
    output src_data,
    input  src_ready,
    input  tx_req,
    input  tx_data,
    output tx_ack
  );
endinterface

// File: rtl/sa_cdc_hs_tx.sv
// Two-phase (toggle) request/acknowledge transmitter for crossing a data word
// into another clock domain. A word is captured into tx_data and tx_req is
// toggled; the block then waits until the synchronised ack toggle matches
// tx_req before accepting the next word. An optional watchdog flags a missing
// ack, and an ack toggle with nothing outstanding flags a protocol error.
module sa_cdc_hs_tx #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              clr_,
  sa_cdc_hs_tx_if.master    hs,
  output logic              busy,
  output logic              err_to,
  output logic              err_proto
);

  // Counter must hold TIMEOUT itself; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t        state;
  logic          tx_req_q;
  logic [DW-1:0] tx_data_q;
  logic [CW-1:0] to_cnt;
  logic          ack_s0;
  logic          ack_s1;
  logic          ack_sync;

  // Saturating increment: the watchdog stops at its limit rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == TO_MAX) ? v : v + 1'b1;
  endfunction

  // Three-flop synchroniser; raw tx_ack is used nowhere else.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      ack_s0   <= 1'b0;
      ack_s1   <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_s0   <= hs.tx_ack;
      ack_s1   <= ack_s0;
      ack_sync <= ack_s1;
    end
  end

  // Handshake FSM with data capture, ack watchdog and sticky error flags.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state     <= IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      to_cnt    <= '0;
      err_to    <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Ack must already match req while nothing is outstanding.
          if (ack_sync != tx_req_q) begin
            err_proto <= 1'b1;
          end
          if (hs.src_valid) begin
            tx_data_q <= hs.src_data;
            tx_req_q  <= ~tx_req_q;
            to_cnt    <= '0;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // Watchdog only reports; the transfer keeps waiting for its ack.
          if (TIMEOUT != 0) begin
            to_cnt <= sat_inc(to_cnt);
            if (sat_inc(to_cnt) == TO_MAX) begin
              err_to <= 1'b1;
            end
          end
          if (ack_sync == tx_req_q) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Outputs decode from registered state only; no path from src_valid or ack.
  assign hs.src_ready = (state == IDLE);
  assign hs.tx_req    = tx_req_q;
  assign hs.tx_data   = tx_data_q;
  assign busy         = (state == WAIT_ACK);

endmodule

// File: tb/tb_sa_cdc_hs_tx.sv
// Directed bench for sa_cdc_hs_tx: a per-cycle vector table for two complete
// transfers, then hand-written sequences for the protocol error, asynchronous
// reset mid-transfer, and the ack watchdog on a short-timeout instance.
module tb_sa_cdc_hs_tx;

  logic clk;
  logic clr_;

  logic m_busy, m_err_to, m_err_proto;
  logic t_busy, t_err_to, t_err_proto;

  sa_cdc_hs_tx_if #(.DW(32)) m_if ();
  sa_cdc_hs_tx_if #(.DW(32)) t_if ();

  sa_cdc_hs_tx #(.DW(32)) dut (
    .clk       (clk),
    .clr_      (clr_),
    .hs        (m_if),
    .busy      (m_busy),
    .err_to    (m_err_to),
    .err_proto (m_err_proto)
  );

  sa_cdc_hs_tx #(.DW(32), .TIMEOUT(8)) dut_to (
    .clk       (clk),
    .clr_      (clr_),
    .hs        (t_if),
    .busy      (t_busy),
    .err_to    (t_err_to),
    .err_proto (t_err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ack;
    logic        ready;
    logic        req;
    logic [31:0] xdata;
    logic        busy;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // inputs applied before the edge -> outputs expected just after it
    vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[1]  = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[3]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[4]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[5]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[6]  = '{1'b1, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[7]  = '{1'b1, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[8]  = '{1'b1, 32'h55555555, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b1};
    vecs[11] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b1};
    vecs[12] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1};
    vecs[13] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1};
    vecs[14] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1};
    vecs[15] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0};

    clr_ = 1'b0;
    m_if.src_valid = 1'b0; m_if.src_data = '0; m_if.tx_ack = 1'b0;
    t_if.src_valid = 1'b0; t_if.src_data = '0; t_if.tx_ack = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   {31'd0, m_if.src_ready}, 32'd1);
    chk("rst_req",     {31'd0, m_if.tx_req},    32'd0);
    chk("rst_data",    m_if.tx_data,            32'd0);
    chk("rst_busy",    {31'd0, m_busy},         32'd0);
    chk("rst_err_to",  {31'd0, m_err_to},       32'd0);
    chk("rst_err_pr",  {31'd0, m_err_proto},    32'd0);
    chk("rst_t_ready", {31'd0, t_if.src_ready}, 32'd1);
    @(negedge clk);
    clr_ = 1'b1;

    // Two full transfers, one vector per clock
    for (int i = 0; i < 16; i++) begin
      m_if.src_valid = vecs[i].valid;
      m_if.src_data  = vecs[i].data;
      m_if.tx_ack    = vecs[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, m_if.src_ready}, {31'd0, vecs[i].ready});
      chk($sformatf("v%0d_req", i),   {31'd0, m_if.tx_req},    {31'd0, vecs[i].req});
      chk($sformatf("v%0d_data", i),  m_if.tx_data,            vecs[i].xdata);
      chk($sformatf("v%0d_busy", i),  {31'd0, m_busy},         {31'd0, vecs[i].busy});
      chk($sformatf("v%0d_errs", i),  {30'd0, m_err_to, m_err_proto}, 32'd0);
    end
    m_if.src_valid = 1'b0;

    // Ack toggle while idle: err_proto after the third edge, sticky
    m_if.tx_ack = 1'b1;
    @(posedge clk); #1;
    chk("proto_e0", {31'd0, m_err_proto}, 32'd0);
    @(posedge clk); #1;
    chk("proto_e1", {31'd0, m_err_proto}, 32'd0);
    @(posedge clk); #1;
    chk("proto_e2", {31'd0, m_err_proto}, 32'd0);
    @(posedge clk); #1;
    chk("proto_e3", {31'd0, m_err_proto}, 32'd1);
    @(posedge clk); #1;
    chk("proto_sticky", {31'd0, m_err_proto}, 32'd1);
    chk("proto_no_to",  {31'd0, m_err_to},    32'd0);
    #2;
    clr_ = 1'b0;
    m_if.tx_ack = 1'b0;
    #1;
    chk("proto_clr", {31'd0, m_err_proto}, 32'd0);
    @(negedge clk);
    clr_ = 1'b1;

    // Asynchronous reset in the middle of a transfer
    m_if.src_valid = 1'b1;
    m_if.src_data  = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("ar_busy", {31'd0, m_busy},      32'd1);
    chk("ar_req",  {31'd0, m_if.tx_req}, 32'd1);
    chk("ar_data", m_if.tx_data,         32'hCAFEF00D);
    m_if.src_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    clr_ = 1'b0;
    #1;
    chk("ar_rst_ready", {31'd0, m_if.src_ready}, 32'd1);
    chk("ar_rst_req",   {31'd0, m_if.tx_req},    32'd0);
    chk("ar_rst_data",  m_if.tx_data,            32'd0);
    chk("ar_rst_busy",  {31'd0, m_busy},         32'd0);
    @(negedge clk);
    clr_ = 1'b1;

    // Watchdog on the TIMEOUT=8 instance, ack held low
    t_if.src_valid = 1'b1;
    t_if.src_data  = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("to_accept_busy", {31'd0, t_busy},      32'd1);
    chk("to_accept_req",  {31'd0, t_if.tx_req}, 32'd1);
    t_if.src_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(posedge clk); #1;
    chk("to_e7_err", {31'd0, t_err_to}, 32'd0);
    @(posedge clk); #1;
    chk("to_e8_err",  {31'd0, t_err_to}, 32'd1);
    chk("to_e8_busy", {31'd0, t_busy},   32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("to_still_busy", {31'd0, t_busy},   32'd1);
    chk("to_sat_err",    {31'd0, t_err_to}, 32'd1);
    // Late ack still completes with the usual latency
    t_if.tx_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    chk("to_late_n2_busy", {31'd0, t_busy}, 32'd1);
    @(posedge clk); #1;
    chk("to_late_n3_busy",  {31'd0, t_busy},         32'd0);
    chk("to_late_n3_ready", {31'd0, t_if.src_ready}, 32'd1);
    chk("to_late_err_to",   {31'd0, t_err_to},       32'd1);
    chk("to_late_err_pr",   {31'd0, t_err_proto},    32'd0);
    chk("to_late_data",     t_if.tx_data,            32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
